// File: rtl/imem_fetch_responder_pkg.sv
// +-----------------------------------------------------------------------------+
// | riscv_types : shared widths, NOP encoding and fetch-responder state type     |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

package riscv_types;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        IMEM_BOOT,
        IMEM_RUN
    } imem_state_t;

    // Byte offset from the RAM base, ignoring the thread-tag bits; wraps so that
    // addresses below the base land far out of range.
    function automatic logic [XLEN-3:0] word_offset(input logic [XLEN-1:0] addr,
                                                   input logic [XLEN-1:0] base);
        return addr[XLEN-3:0] - base[XLEN-3:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_fetch_responder_ram.sv
// +-----------------------------------------------------------------------------+
// | imem_ram : 1R1W synchronous instruction RAM, read-enable, read-first         |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module imem_ram #(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/imem_fetch_responder.sv
// +-----------------------------------------------------------------------------+
// | imem_fetch_responder : IFU fetch responder with BOOT/RUN gating and loader   |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module imem_fetch_responder
    import riscv_types::*;
#(
    parameter int              DEPTH_WORDS = 4096,
    parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0200
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic [1:0]      req_tid,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_data,
    output logic [1:0]      rsp_tid,
    output logic [XLEN-1:0] rsp_addr,
    output logic            rsp_err,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [XLEN-1:0] ld_addr,
    input  logic [31:0]     ld_data,
    input  logic            ld_done,
    output logic            boot_done
);

    localparam int              AW   = $clog2(DEPTH_WORDS);
    localparam logic [XLEN-3:0] SPAN = (XLEN-2)'(4 * DEPTH_WORDS);

    imem_state_t state;
    imem_state_t state_next;

    logic [XLEN-3:0] fetch_off;
    logic [XLEN-3:0] load_off;
    logic            fetch_ok;
    logic            load_ok;
    logic            accept;
    logic            ram_we;
    logic            ram_re;
    logic [31:0]     ram_q;
    logic            rsp_from_ram;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IMEM_BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IMEM_BOOT: if (ld_done) state_next = IMEM_RUN;
            IMEM_RUN:  state_next = IMEM_RUN;
            default:   state_next = IMEM_BOOT;
        endcase
    end

    assign boot_done = (state == IMEM_RUN);
    assign ld_ready  = 1'b1;

    // Offset bits [1:0] equal address bits [1:0] because the base is word aligned.
    assign fetch_off = word_offset(req_addr, BASE_ADDR);
    assign load_off  = word_offset(ld_addr, BASE_ADDR);
    assign fetch_ok  = (fetch_off < SPAN) && (fetch_off[1:0] == 2'b00);
    assign load_ok   = (load_off < SPAN) && (load_off[1:0] == 2'b00);

    // The loader owns the RAM port whenever it is active, so fetch yields.
    assign req_ready = boot_done && !ld_valid && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign ram_we    = ld_valid && load_ok;
    assign ram_re    = accept && fetch_ok;

    imem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (load_off[AW+1:2]),
        .wdata (ld_data),
        .re    (ram_re),
        .raddr (fetch_off[AW+1:2]),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid    <= 1'b0;
            rsp_tid      <= 2'd0;
            rsp_addr     <= '0;
            rsp_err      <= 1'b0;
            rsp_from_ram <= 1'b0;
        end else if (accept) begin
            rsp_valid    <= 1'b1;
            rsp_tid      <= req_tid;
            rsp_addr     <= req_addr;
            rsp_err      <= !fetch_ok;
            rsp_from_ram <= fetch_ok;
        end else if (rsp_ready) begin
            rsp_valid    <= 1'b0;
        end
    end

    // RAM output only moves on a read, so it stays stable under backpressure.
    assign rsp_data = rsp_from_ram ? ram_q : NOP_INSTR;

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_responder.sv
// +-----------------------------------------------------------------------------+
// | tb_imem_fetch_responder : directed + random bench with transaction model     |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_imem_fetch_responder;
    import riscv_types::*;

    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_tid = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_tid;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        ld_done = 1'b0;
    logic        boot_done;

    imem_fetch_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_tid   (req_tid),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tid   (rsp_tid),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_done   (ld_done),
        .boot_done (boot_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: memory image plus the one expected outstanding response.
    logic [31:0] mem_m   [DEPTH];
    bit          known_m [DEPTH];
    bit          m_run, m_vld, m_err, m_known, m_show;
    logic [1:0]  m_tid;
    logic [31:0] m_addr, m_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit decode(input logic [31:0] a, output int idx);
        int unsigned off;
        off = ((a & 32'h3FFF_FFFF) - BASE) & 32'h3FFF_FFFF;
        idx = int'(off / 4) % DEPTH;
        return (off < 4 * DEPTH) && (a % 4 == 0);
    endfunction

    task automatic step(input logic rv, input logic [31:0] ra, input logic [1:0] rt,
                        input logic rr, input logic lv, input logic [31:0] la,
                        input logic [31:0] ldat, input logic done, input logic rstn);
        bit exp_ready, ok;
        int idx;
        req_valid = rv; req_addr = ra; req_tid = rt; rsp_ready = rr;
        ld_valid = lv; ld_addr = la; ld_data = ldat; ld_done = done; rst = rstn;
        #1;
        exp_ready = m_run && !lv && (!m_vld || rr);
        check("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
        check("ld_ready", {31'd0, ld_ready}, 32'd1);
        @(posedge clk);
        if (lv && decode(la, idx)) begin
            mem_m[idx] = ldat;
            known_m[idx] = 1'b1;
        end
        if (!rstn) begin
            m_run = 0; m_vld = 0; m_err = 0; m_tid = 0; m_addr = 0;
            m_data = NOP_INSTR; m_known = 1; m_show = 1;
        end else begin
            m_show = 0;
            if (rv && exp_ready) begin
                ok      = decode(ra, idx);
                m_vld   = 1;
                m_err   = !ok;
                m_tid   = rt;
                m_addr  = ra;
                m_known = ok ? known_m[idx] : 1'b1;
                m_data  = ok ? mem_m[idx] : NOP_INSTR;
            end else if (rr) begin
                m_vld = 0;
            end
            if (done) m_run = 1;
        end
        @(negedge clk);
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_vld});
        check("boot_done", {31'd0, boot_done}, {31'd0, m_run});
        if (m_vld || m_show) begin
            check("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
            check("rsp_tid", {30'd0, rsp_tid}, {30'd0, m_tid});
            check("rsp_addr", rsp_addr, m_addr);
            if (m_known) check("rsp_data", rsp_data, m_data);
        end
    endtask

    task automatic idle(input logic rr);
        step(0, 0, 0, rr, 0, 0, 0, 0, 1);
    endtask

    task automatic fetch(input logic [31:0] a, input logic [1:0] t, input logic rr);
        step(1, a, t, rr, 0, 0, 0, 0, 1);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        step(0, 0, 0, 1, 1, a, d, 0, 1);
    endtask

    logic [31:0] ra;
    int          sel;

    initial begin
        m_run = 0; m_vld = 0; m_err = 0; m_known = 0; m_show = 0;
        m_tid = 0; m_addr = 0; m_data = NOP_INSTR;
        for (int i = 0; i < DEPTH; i++) begin
            known_m[i] = 0;
            mem_m[i]   = '0;
        end

        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);

        load(32'h200, 32'h0000_0093);
        load(32'h204, 32'h0010_0113);

        // Fetch in BOOT is refused; ld_done with the fetch still presented.
        fetch(32'h200, 0, 1);
        fetch(32'h200, 0, 1);
        step(1, 32'h200, 0, 1, 0, 0, 0, 1, 1);
        fetch(32'h204, 1, 1);
        idle(1);
        fetch(32'h200, 0, 1);
        fetch(32'h204, 1, 1);
        idle(1);

        fetch(32'h202, 2, 1);
        fetch(32'h200 + 4 * DEPTH, 3, 1);
        fetch(32'h1FC, 0, 1);
        idle(1);

        fetch(32'hC000_0204, 2, 1);
        for (int i = 0; i < 3; i++) fetch(32'h200, 1, 0);
        fetch(32'h200, 1, 1);
        idle(1);

        step(1, 32'h208, 3, 1, 1, 32'h208, 32'hDEAD_BEEF, 0, 1);
        fetch(32'h208, 3, 1);
        idle(1);

        load(32'h0000_0206, 32'h1111_1111);
        load(32'h0000_0200 + 4 * DEPTH, 32'h2222_2222);
        for (int i = 0; i < 64; i++) load(BASE + 32'(4 * i), $urandom);

        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       ra = BASE + 32'(4 * $urandom_range(0, 63));
            else if (sel == 7) ra = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
            else if (sel == 8) ra = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 100));
            else               ra = 32'(4 * $urandom_range(0, 127));
            ra[31:30] = 2'($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0, ra, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 6) == 0, BASE + 32'(4 * $urandom_range(0, 63)), $urandom,
                 0, 1);
        end

        // Reset while a response is pending, then fetches gated until ld_done.
        fetch(32'h204, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        fetch(32'h204, 1, 1);
        fetch(32'h204, 1, 1);
        step(1, 32'h204, 1, 1, 0, 0, 0, 1, 1);
        fetch(32'h204, 1, 1);
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
